parallel_to_serial: RTL and testbench
=====================================

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the parallel word width in bits; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port parallel_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port parallel_data, input, width bits: the upstream word.
REQ-006 The block SHALL have port parallel_ready, output, 1 bit: the block accepts the word this cycle.
REQ-007 The block SHALL have port serial_valid, output, 1 bit: serial_data carries a valid bit this cycle.
REQ-008 The block SHALL have port serial_data, output, 1 bit: the serialized bit.
REQ-009 The block SHALL have port busy, output, 1 bit: a word is being shifted out or is held.

Function
REQ-010 A transfer SHALL occur on a rising edge where parallel_valid and parallel_ready are both high; words SHALL be neither lost nor duplicated.
REQ-011 parallel_ready SHALL be decoded from registered state only and SHALL NOT depend combinationally on parallel_valid.
REQ-012 The state machine SHALL have two states: IDLE (no bits pending) and SHIFT (bits pending).
REQ-013 In IDLE, an accepted word SHALL load the shift register, clear the bit counter and move the block to SHIFT.
REQ-014 In SHIFT, serial_valid SHALL be 1 and serial_data SHALL be the current shift-register bit 0; each cycle the register SHALL shift right and the counter SHALL increment.
REQ-015 Bit order SHALL be LSB first, so that serial_to_parallel rebuilds the original word.
REQ-016 Latency: a word accepted on edge N SHALL produce bit 0 in the cycle after edge N and bit width-1 in the cycle after edge N+width-1; serial_valid SHALL be high for exactly width consecutive cycles per word.
REQ-017 serial_valid and serial_data SHALL be driven from flops.
REQ-018 The bit counter SHALL be $clog2(width) bits wide and SHALL reach width-1 on the last bit, also for non-power-of-2 width.
REQ-019 After the last bit, the block SHALL return to IDLE unless a held word exists (REQ-027).
REQ-020 While parallel_valid is high and parallel_ready is low, parallel_data SHALL be ignored.
REQ-021 busy SHALL be 1 in SHIFT and whenever a held word exists, and 0 otherwise.
REQ-022 The block SHALL have no downstream backpressure; serial output SHALL never stall once started.

Reset
REQ-023 While rst is high, the block SHALL enter IDLE, clear the counter and shift register, drive serial_valid=0, serial_data=0 and busy=0, and discard any held word.
REQ-024 A reset asserted mid-word SHALL abort the word: serial_valid SHALL be 0 in the cycle after the reset edge, and no remaining bits SHALL be emitted.
REQ-025 parallel_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-026 Without P2S_SKID_EN, parallel_ready SHALL equal (state==IDLE), giving a minimum one-cycle serial_valid gap between words.
REQ-027 With P2S_SKID_EN, the block SHALL have a one-word holding slot, and parallel_ready SHALL equal (slot empty).
REQ-028 With P2S_SKID_EN, in IDLE an accepted word SHALL go directly to the shift register.
REQ-029 With P2S_SKID_EN, in SHIFT an accepted word SHALL fill the slot.
REQ-030 With P2S_SKID_EN, on the last-bit cycle a full slot SHALL reload the shift register with no gap and empty the slot; a word arriving on that same cycle with the slot empty SHALL load the shift register directly.
REQ-031 With P2S_SKID_EN, there SHALL be no idle cycles between back-to-back words.

Structure
REQ-032 Package p2s_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the counter-width localparam function.
REQ-033 The holding slot SHALL be the sub-module p2s_hold_slot, instantiated only under P2S_SKID_EN.

Verification
REQ-034 A bench SHALL drive a single word 8'hA5 and check serial_data 1,0,1,0,0,1,0,1 on the 8 cycles after acceptance, with serial_valid high exactly 8 cycles and busy falling after the last bit.
REQ-035 A bench SHALL loop the block back into serial_to_parallel, send 8'h3C then 8'hF0, and check parallel_data 8'h3C then 8'hF0, with the receiver's parallel_valid pulsing one cycle after each last bit.
REQ-036 A bench SHALL hold parallel_valid high continuously with words 8'h01 and 8'h02 and check a 1-cycle serial_valid gap without the macro and 16 contiguous valid cycles with it.
REQ-037 A bench SHALL assert rst during bit 3 of 8'hFF and check serial_valid=0 in the next cycle, parallel_ready=1 after release, and no further bits.
REQ-038 A bench SHALL hold parallel_valid high with parallel_ready low, changing the data, and check that exactly one word (the value present on the ready cycle) is serialized.
REQ-039 A bench SHALL run with width=5 and word 5'b10011 and check exactly 5 bits 1,1,0,0,1 followed by a return to IDLE.

Source files
------------

// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared types and sizing helpers for the parallel-to-serial converter
//
// Purpose: FSM state encoding and bit-counter width function used by
//          parallel_to_serial and its holding slot.
// Ports:   none (package)
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,   // no bits pending
    SHIFT = 1'b1    // bits pending on the serial output
  } state_t;

  // Counter must be able to hold width-1; width is at least 2, so this is >= 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/p2s_hold_slot.sv
// rtl/p2s_hold_slot.sv - one-word holding slot used when the skid option is built in
//
// Purpose: stores one upstream word accepted while a previous word is still
//          shifting, so it can be reloaded with no idle cycle.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, empties the slot
//   wr_en    in   capture wr_data into the slot (only issued while empty)
//   wr_data  in   word to capture
//   rd_en    in   release the slot (only issued while full)
//   full     out  slot holds a word
//   data     out  held word
module p2s_hold_slot #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [width-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - valid/ready parallel word to LSB-first serial bit stream
//
// Purpose: accepts a width-bit word on a valid/ready handshake and emits it
//          one bit per cycle, LSB first, with serial_valid high for exactly
//          width cycles per word. No downstream backpressure.
// Build option: define P2S_SKID_EN to add a one-word holding slot that lets
//          back-to-back words stream with no idle cycle between them.
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset, aborts any word in flight
//   parallel_valid  in   upstream word valid
//   parallel_data   in   upstream word [width-1:0]
//   parallel_ready  out  word is accepted this cycle (from registered state only)
//   serial_valid    out  serial_data carries a bit this cycle
//   serial_data     out  serialized bit
//   busy            out  a word is shifting or held
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             busy
);

  import p2s_pkg::*;

  localparam int             CW       = cnt_width(width);
  localparam logic [CW-1:0]  LAST_BIT = CW'(width - 1);

  state_t           state;
  logic [width-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             sv_q;

  logic             accept;
  logic             last_bit;
  logic             load_en;
  logic [width-1:0] load_word;

  assign accept   = parallel_valid && parallel_ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

`ifdef P2S_SKID_EN
  logic             slot_full;
  logic [width-1:0] slot_data;
  logic             slot_wr;
  logic             slot_rd;

  // A held word always wins the last-bit reload; ready is low while it is
  // held, so an upstream word cannot compete for the same cycle.
  assign slot_rd        = last_bit && slot_full;
  assign slot_wr        = accept && (state == SHIFT) && !last_bit;
  assign load_en        = slot_rd || (accept && ((state == IDLE) || last_bit));
  assign load_word      = slot_rd ? slot_data : parallel_data;
  assign parallel_ready = !slot_full;
  assign busy           = (state == SHIFT) || slot_full;

  p2s_hold_slot #(
    .width(width)
  ) u_hold_slot (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (slot_wr),
    .wr_data (parallel_data),
    .rd_en   (slot_rd),
    .full    (slot_full),
    .data    (slot_data)
  );
`else
  // Ready only in IDLE, so accepts never overlap a word in flight.
  assign load_en        = accept;
  assign load_word      = parallel_data;
  assign parallel_ready = (state == IDLE);
  assign busy           = (state == SHIFT);
`endif

  // Bit 0 of the shift register is the serial bit; zero fill leaves the
  // register cleared after the last shift so serial_data idles low.
  assign serial_data  = shreg[0];
  assign serial_valid = sv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      sv_q  <= 1'b0;
    end else if (load_en) begin
      state <= SHIFT;
      shreg <= load_word;
      cnt   <= '0;
      sv_q  <= 1'b1;
    end else if (state == SHIFT) begin
      shreg <= shreg >> 1;
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
        sv_q  <= 1'b0;
      end else begin
        cnt   <= cnt + 1'b1;
        sv_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed vector bench for parallel_to_serial
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       pv, pr, sv, sd, bz;
  logic [7:0] pd;
  logic       pv5, pr5, sv5, sd5, bz5;
  logic [4:0] pd5;

  always #5 clk = ~clk;

  parallel_to_serial #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .parallel_valid(pv), .parallel_data(pd),
    .parallel_ready(pr), .serial_valid(sv), .serial_data(sd), .busy(bz)
  );

  parallel_to_serial #(.width(5)) dut5 (
    .clk(clk), .rst(rst), .parallel_valid(pv5), .parallel_data(pd5),
    .parallel_ready(pr5), .serial_valid(sv5), .serial_data(sd5), .busy(bz5)
  );

  // Receiver model: LSB-first deserializer, word strobe one cycle after last bit.
  logic [7:0] rx_sh, rx_word;
  logic [2:0] rx_cnt;
  logic       rx_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh    <= '0;
      rx_word  <= '0;
      rx_cnt   <= '0;
      rx_pulse <= 1'b0;
    end else begin
      rx_pulse <= 1'b0;
      if (sv) begin
        rx_sh  <= {sd, rx_sh[7:1]};
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          rx_word  <= {sd, rx_sh[7:1]};
          rx_pulse <= 1'b1;
        end
      end
    end
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send8(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    pv = 1'b1;
    pd = w;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (pr) ok = 1'b1;
      @(negedge clk);
    end
    pv = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;   // serial bits in time order, first bit leftmost
  } vec_t;

  vec_t tbl [8];

  logic [19:0] svv, sdv, exp_svv, exp_sdv;
  logic [23:0] stream;
  logic [7:0]  want [3];
  int          n_acc, nbits, k, cnt_hi;
  bit          drop;
  logic [4:0]  exp5;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8'b10100101};
    tbl[1] = '{8'h3C, 8'b00111100};
    tbl[2] = '{8'hF0, 8'b00001111};
    tbl[3] = '{8'h01, 8'b10000000};
    tbl[4] = '{8'h80, 8'b00000001};
    tbl[5] = '{8'h13, 8'b11001000};
    tbl[6] = '{8'hFF, 8'b11111111};
    tbl[7] = '{8'h00, 8'b00000000};

    rst = 1'b1; pv = 1'b0; pd = '0; pv5 = 1'b0; pd5 = '0;
    repeat (3) @(negedge clk);
    chk("rst_serial_valid", sv, 0);
    chk("rst_serial_data", sd, 0);
    chk("rst_busy", bz, 0);
    chk("rst5_serial_valid", sv5, 0);
    chk("rst5_busy", bz5, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", pr, 1);

    // Table: single words, serial bit order, timing, receiver loopback.
    for (int i = 0; i < 8; i++) begin
      send8(tbl[i].word);
      for (int b = 0; b < 8; b++) begin
        chk($sformatf("v%0d_valid_b%0d", i, b), sv, 1);
        chk($sformatf("v%0d_data_b%0d", i, b), sd, tbl[i].seq[7-b]);
        chk($sformatf("v%0d_busy_b%0d", i, b), bz, 1);
        @(negedge clk);
      end
      chk($sformatf("v%0d_valid_end", i), sv, 0);
      chk($sformatf("v%0d_busy_end", i), bz, 0);
      chk($sformatf("v%0d_rx_pulse", i), rx_pulse, 1);
      chk($sformatf("v%0d_rx_word", i), rx_word, tbl[i].word);
    end

    // Continuous valid with 01 then 02: gap depends on the skid option.
`ifdef P2S_SKID_EN
    exp_svv = 20'b0000_11111111_11111111;
    exp_sdv = 20'b0000_00000010_00000001;
`else
    exp_svv = 20'b000_11111111_0_11111111;
    exp_sdv = 20'b000_00000010_0_00000001;
`endif
    pv = 1'b1; pd = 8'h01;
    chk("b2b_first_ready", pr, 1);
    @(negedge clk);
    n_acc = 1; pd = 8'h02; drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      svv[i] = sv;
      sdv[i] = sd;
      if (drop) pv = 1'b0;
      else if (pv && pr) begin
        n_acc++;
        if (n_acc == 2) drop = 1'b1;
      end
      @(negedge clk);
    end
    pv = 1'b0;
    chk("b2b_valid_pattern", svv, exp_svv);
    chk("b2b_data_pattern", sdv, exp_sdv);
    chk("b2b_accepts", n_acc, 2);
    repeat (3) @(negedge clk);

    // Valid held high while not ready: data changes must be ignored.
    want[0] = 8'h0F; want[1] = 8'h66; want[2] = 8'hC3;
    k = 0; nbits = 0; stream = '0;
    for (int i = 0; i < 80; i++) begin
      if (sv) begin
        if (nbits < 24) stream[nbits] = sd;
        nbits++;
      end
      if (k < 3) begin
        pv = 1'b1;
        if (pr) begin
          pd = want[k];
          k++;
        end else begin
          pd = 8'hE0 ^ i[7:0];
        end
      end else begin
        pv = 1'b0;
      end
      @(negedge clk);
    end
    pv = 1'b0;
    chk("hold_words_sent", k, 3);
    chk("hold_bit_count", nbits, 24);
    chk("hold_stream", stream, 24'hC3660F);

    // Reset during bit 3 of FF aborts the word.
    send8(8'hFF);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("abort_data_b%0d", b), sd, 1);
      @(negedge clk);
    end
    chk("abort_valid_b3", sv, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid_after_rst", sv, 0);
    chk("abort_data_after_rst", sd, 0);
    chk("abort_busy_after_rst", bz, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after_release", pr, 1);
    cnt_hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (sv) cnt_hi++;
      @(negedge clk);
    end
    chk("abort_no_more_bits", cnt_hi, 0);

    // Non-power-of-2 width: 5'b10011 -> 1,1,0,0,1.
    exp5 = 5'b11001;
    chk("w5_ready", pr5, 1);
    pv5 = 1'b1; pd5 = 5'b10011;
    @(negedge clk);
    pv5 = 1'b0;
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("w5_valid_b%0d", b), sv5, 1);
      chk($sformatf("w5_data_b%0d", b), sd5, exp5[4-b]);
      @(negedge clk);
    end
    chk("w5_valid_end", sv5, 0);
    chk("w5_busy_end", bz5, 0);
    chk("w5_ready_end", pr5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
